// File: rtl/mmp_cdc_tx_sched.sv
// mmp_cdc_tx_sched: round-robin scheduler feeding NUM_CH audio sources into one
// 16-bit sample CDC channel (request/acknowledge).
// Each source has a one-deep holding register.
// Overruns are counted and flagged.
// Acknowledge waits are bounded by TMO cycles.
// All outputs are registered.
module mmp_cdc_tx_sched #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int TMO    = 255
) (
  input  logic                       i_CLK_A,
  input  logic                       i_RST_n,
  input  logic [NUM_CH-1:0]          i_SMPL_VLD,
  input  logic signed [16*NUM_CH-1:0] i_SMPL_DATA,
  output logic                       o_XFER_REQ,
  output logic signed [15:0]         o_XFER_DATA,
  output logic [CH_W-1:0]            o_XFER_CH,
  input  logic                       i_XFER_ACK,
  output logic                       o_BUSY,
  output logic [NUM_CH-1:0]          o_OVR,
  output logic                       o_TMO,
  output logic [7:0]                 o_DROP_CNT,
  input  logic                       i_FLAG_CLR
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]        r_state;
  logic [NUM_CH-1:0] r_pend;
  logic [CH_W-1:0]   r_last;
  logic [7:0]        r_tmo;
  logic [15:0]       r_hold [NUM_CH];
  logic              r_req;
  logic [15:0]       r_data;
  logic [CH_W-1:0]   r_ch;
  logic              r_busy;
  logic [NUM_CH-1:0] r_ovr;
  logic              r_tmo_flag;
  logic [7:0]        r_drop;

  logic [CH_W-1:0]   w_cand [NUM_CH];
  logic              w_grant_vld;
  logic [CH_W-1:0]   w_grant_idx;
  logic              w_do_grant;
  logic [NUM_CH-1:0] w_gnt_mask;
  logic [NUM_CH-1:0] w_ovr_hit;
  logic [3:0]        w_ovr_num;
  logic [8:0]        w_drop_sum;
  logic [7:0]        w_drop_next;
  logic [NUM_CH-1:0] w_pend_next;
  logic [1:0]        w_state_next;
  logic [7:0]        w_tmo_next;
  logic              w_tmo_hit;

  genvar gi;

  // Candidate order for the cyclic search: position i is source (last+1+i) mod NUM_CH
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_cand
      assign w_cand[gi] = CH_W'((int'(r_last) + gi + 1) % NUM_CH);
    end
  endgenerate

  // First pending source after the last granted one (lowest position wins)
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_pend[w_cand[i]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand[i];
      end
    end
  end

  assign w_do_grant = (r_state == ST_IDLE) && w_grant_vld;

  // Grant mask, overrun detection (a granted source is never an overrun) and pend update
  always_comb begin
    w_gnt_mask = '0;
    if (w_do_grant) w_gnt_mask[w_grant_idx] = 1'b1;
    w_ovr_hit   = i_SMPL_VLD & r_pend & ~w_gnt_mask;
    w_pend_next = (r_pend & ~w_gnt_mask) | i_SMPL_VLD;
  end

  // Count simultaneous overruns and add them to the drop counter with saturation
  always_comb begin
    w_ovr_num = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_ovr_num = w_ovr_num + 4'(w_ovr_hit[k]);
    end
    w_drop_sum  = {1'b0, r_drop} + {5'b0, w_ovr_num};
    w_drop_next = (w_drop_sum > 9'd255) ? 8'd255 : w_drop_sum[7:0];
  end

  // Transfer FSM: IDLE grants, REQ waits for ack or timeout, GAP forces one low cycle
  always_comb begin
    w_state_next = r_state;
    w_tmo_next   = r_tmo;
    w_tmo_hit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_do_grant) begin
          w_state_next = ST_REQ;
          w_tmo_next   = 8'd0;
        end
      end
      ST_REQ: begin
        if (i_XFER_ACK) begin
          w_state_next = ST_GAP;
        end else if (({1'b0, r_tmo} + 9'd1) == 9'(TMO)) begin
          w_state_next = ST_GAP;
          w_tmo_hit    = 1'b1;
        end else begin
          w_tmo_next = r_tmo + 8'd1;
        end
      end
      ST_GAP:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Per-source holding registers; a new strobe always overwrites the held sample
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_hold
      always_ff @(posedge i_CLK_A) begin
        if (!i_RST_n) begin
          r_hold[gi] <= '0;
        end else if (i_SMPL_VLD[gi]) begin
          r_hold[gi] <= i_SMPL_DATA[16*gi +: 16];
        end
      end
    end
  endgenerate

  // Scheduler state, registered outputs and sticky status
  always_ff @(posedge i_CLK_A) begin
    if (!i_RST_n) begin
      r_state    <= ST_IDLE;
      r_pend     <= '0;
      r_last     <= CH_W'(NUM_CH - 1);
      r_tmo      <= '0;
      r_req      <= 1'b0;
      r_data     <= '0;
      r_ch       <= '0;
      r_busy     <= 1'b0;
      r_ovr      <= '0;
      r_tmo_flag <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_state <= w_state_next;
      r_tmo   <= w_tmo_next;
      r_pend  <= w_pend_next;
      if (w_do_grant) begin
        r_data <= r_hold[w_grant_idx];
        r_ch   <= w_grant_idx;
        r_last <= w_grant_idx;
      end
      r_req  <= (w_state_next == ST_REQ);
      r_busy <= (w_state_next != ST_IDLE) || (|w_pend_next);
      if (i_FLAG_CLR) begin
        r_ovr      <= '0;
        r_tmo_flag <= 1'b0;
        r_drop     <= '0;
      end else begin
        r_ovr  <= r_ovr | w_ovr_hit;
        r_drop <= w_drop_next;
        if (w_tmo_hit) r_tmo_flag <= 1'b1;
      end
    end
  end

  assign o_XFER_REQ  = r_req;
  assign o_XFER_DATA = r_data;
  assign o_XFER_CH   = r_ch;
  assign o_BUSY      = r_busy;
  assign o_OVR       = r_ovr;
  assign o_TMO       = r_tmo_flag;
  assign o_DROP_CNT  = r_drop;

endmodule

// File: tb/tb_mmp_cdc_tx_sched.sv
// tb_mmp_cdc_tx_sched: directed scenarios plus a randomized run checked against
// a transaction-level reference model of the scheduler.
module tb_mmp_cdc_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  vld;
  logic [15:0] d [4];
  logic [63:0] sdata;
  logic        ack;
  logic        clr;
  logic        o_req;
  logic [15:0] o_data;
  logic [1:0]  o_ch;
  logic        o_busy;
  logic [3:0]  o_ovr;
  logic        o_tmo;
  logic [7:0]  o_drop;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign sdata = {d[3], d[2], d[1], d[0]};

  mmp_cdc_tx_sched #(.NUM_CH(4), .CH_W(2), .TMO(8)) dut (
    .i_CLK_A     (clk),
    .i_RST_n     (rst_n),
    .i_SMPL_VLD  (vld),
    .i_SMPL_DATA (sdata),
    .o_XFER_REQ  (o_req),
    .o_XFER_DATA (o_data),
    .o_XFER_CH   (o_ch),
    .i_XFER_ACK  (ack),
    .o_BUSY      (o_busy),
    .o_OVR       (o_ovr),
    .o_TMO       (o_tmo),
    .o_DROP_CNT  (o_drop),
    .i_FLAG_CLR  (clr)
  );

  // Leaves the bench at the falling edge that starts cycle 0 after reset
  task automatic do_reset();
    rst_n = 1'b0;
    vld = '0; ack = 1'b0; clr = 1'b0;
    for (int k = 0; k < 4; k++) d[k] = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({o_req, o_data, o_ch, o_busy, o_ovr, o_tmo, o_drop} !== 32'd0)
      $display("FAIL reset_state got req=%0b data=%h ch=%0d busy=%0b ovr=%b tmo=%0b drop=%0d exp all 0",
               o_req, o_data, o_ch, o_busy, o_ovr, o_tmo, o_drop);
    if ({o_req, o_data, o_ch, o_busy, o_ovr, o_tmo, o_drop} !== 32'd0) n_fail++;
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      vld = (c == 0) ? 4'b0100 : 4'b0000;
      if (c == 0) d[2] = 16'sh8001;
      ack = (c == 4);
      n_tests++;
      if (o_req !== (c >= 2 && c <= 4)) begin
        n_fail++;
        $display("FAIL single_req cycle=%0d got=%0b exp=%0b", c, o_req, (c >= 2 && c <= 4));
      end
      if (c >= 2 && c <= 4) begin
        n_tests++;
        if (o_ch !== 2'd2 || o_data !== 16'h8001) begin
          n_fail++;
          $display("FAIL single_xfer cycle=%0d got ch=%0d data=%h exp ch=2 data=8001", c, o_ch, o_data);
        end
      end
      if (c == 5 || c == 6) begin
        n_tests++;
        if (o_busy !== (c == 5)) begin
          n_fail++;
          $display("FAIL single_busy cycle=%0d got=%0b exp=%0b", c, o_busy, (c == 5));
        end
      end
      @(negedge clk);
    end
    $display("[TB] single: ch2 transfer done");
  endtask

  task automatic test_fairness();
    logic [1:0]  got_ch [$];
    logic [15:0] got_d [$];
    int          exp_ch [6] = '{0, 1, 2, 3, 0, 3};
    int          exp_d  [6] = '{1, 2, 3, 4, 16'h10, 16'h13};
    bit          re = 1'b0;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      vld = '0; ack = 1'b0;
      if (c == 0) begin
        vld = 4'hF;
        d[0] = 16'd1; d[1] = 16'd2; d[2] = 16'd3; d[3] = 16'd4;
      end
      if (o_req) begin
        got_ch.push_back(o_ch);
        got_d.push_back(o_data);
        $display("[TB] fairness: xfer ch=%0d data=%h", o_ch, o_data);
        ack = 1'b1;
        if (o_ch == 2'd3 && !re) begin
          re = 1'b1;
          vld = 4'b1001;
          d[0] = 16'h0010; d[3] = 16'h0013;
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (got_ch.size() != 6) begin
      n_fail++;
      $display("FAIL fair_count got=%0d exp=6", got_ch.size());
    end
    for (int i = 0; i < 6 && i < got_ch.size(); i++) begin
      n_tests++;
      if (int'(got_ch[i]) != exp_ch[i] || int'(got_d[i]) != exp_d[i]) begin
        n_fail++;
        $display("FAIL fair_order idx=%0d got ch=%0d data=%h exp ch=%0d data=%h",
                 i, got_ch[i], got_d[i], exp_ch[i], exp_d[i]);
      end
    end
    n_tests++;
    if (o_ovr !== 4'b0000 || o_drop !== 8'd0) begin
      n_fail++;
      $display("FAIL fair_no_ovr got ovr=%b drop=%0d exp 0/0", o_ovr, o_drop);
    end
  endtask

  task automatic test_overrun();
    logic [1:0]  got_ch [$];
    logic [15:0] got_d [$];
    do_reset();
    for (int c = 0; c < 16; c++) begin
      vld = '0; ack = 1'b0;
      if (c == 0) begin vld = 4'b0011; d[0] = 16'h00AA; d[1] = 16'd5; end
      if (c == 2) begin vld = 4'b0010; d[1] = 16'd6; end
      if (o_req) begin
        got_ch.push_back(o_ch); got_d.push_back(o_data); ack = 1'b1;
        $display("[TB] overrun: xfer ch=%0d data=%h", o_ch, o_data);
      end
      if (c == 2 || c == 3) begin
        n_tests++;
        if (o_ovr !== ((c == 3) ? 4'b0010 : 4'b0000) || o_drop !== ((c == 3) ? 8'd1 : 8'd0)) begin
          n_fail++;
          $display("FAIL ovr_flag cycle=%0d got ovr=%b drop=%0d", c, o_ovr, o_drop);
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (got_ch.size() != 2 || got_ch[0] !== 2'd0 || got_d[0] !== 16'h00AA ||
        got_ch[1] !== 2'd1 || got_d[1] !== 16'd6) begin
      n_fail++;
      $display("FAIL ovr_xfers got n=%0d exp (0,00aa),(1,0006)", got_ch.size());
    end
    n_tests++;
    if (o_ovr !== 4'b0010 || o_drop !== 8'd1) begin
      n_fail++;
      $display("FAIL ovr_sticky got ovr=%b drop=%0d exp 0010/1", o_ovr, o_drop);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_tests++;
    if (o_ovr !== 4'b0000 || o_drop !== 8'd0) begin
      n_fail++;
      $display("FAIL ovr_clear got ovr=%b drop=%0d exp 0/0", o_ovr, o_drop);
    end
  endtask

  task automatic test_collision();
    logic [1:0]  got_ch [$];
    logic [15:0] got_d [$];
    do_reset();
    for (int c = 0; c < 16; c++) begin
      vld = '0; ack = 1'b0;
      if (c == 0) begin vld = 4'b0001; d[0] = 16'h1111; end
      if (c == 1) begin vld = 4'b0001; d[0] = 16'h2222; end
      if (o_req) begin
        got_ch.push_back(o_ch); got_d.push_back(o_data); ack = 1'b1;
        $display("[TB] collision: xfer ch=%0d data=%h", o_ch, o_data);
      end
      @(negedge clk);
    end
    n_tests++;
    if (got_ch.size() != 2 || got_d[0] !== 16'h1111 || got_d[1] !== 16'h2222 ||
        got_ch[0] !== 2'd0 || got_ch[1] !== 2'd0) begin
      n_fail++;
      $display("FAIL collision_xfers got n=%0d exp (0,1111),(0,2222)", got_ch.size());
    end
    n_tests++;
    if (o_ovr !== 4'b0000 || o_drop !== 8'd0) begin
      n_fail++;
      $display("FAIL collision_ovr got ovr=%b drop=%0d exp 0/0", o_ovr, o_drop);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 15; c++) begin
      vld = '0;
      if (c == 0) begin vld = 4'b0110; d[1] = 16'h0111; d[2] = 16'h0222; end
      ack = (c == 12) && o_req;
      n_tests++;
      if (o_req !== ((c >= 2 && c <= 9) || c == 12) || o_tmo !== (c >= 10)) begin
        n_fail++;
        $display("FAIL tmo_timing cycle=%0d got req=%0b tmo=%0b exp req=%0b tmo=%0b",
                 c, o_req, o_tmo, ((c >= 2 && c <= 9) || c == 12), (c >= 10));
      end
      if (c == 2 || c == 12) begin
        n_tests++;
        if (o_ch !== ((c == 2) ? 2'd1 : 2'd2) || o_data !== ((c == 2) ? 16'h0111 : 16'h0222)) begin
          n_fail++;
          $display("FAIL tmo_xfer cycle=%0d got ch=%0d data=%h", c, o_ch, o_data);
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (o_drop !== 8'd0) begin
      n_fail++;
      $display("FAIL tmo_drop got=%0d exp=0", o_drop);
    end
    $display("[TB] timeout: ch1 abandoned, ch2 served");
  endtask

  task automatic test_saturate();
    do_reset();
    for (int c = 0; c < 200; c++) begin
      vld = 4'hF;
      for (int k = 0; k < 4; k++) d[k] = 16'($urandom);
      ack = o_req && ($urandom_range(0, 1) == 1);
      @(negedge clk);
    end
    n_tests++;
    if (o_drop !== 8'd255 || o_ovr !== 4'hF) begin
      n_fail++;
      $display("FAIL drop_saturate got drop=%0d ovr=%b exp 255/1111", o_drop, o_ovr);
    end
    clr = 1'b1;
    vld = 4'hF;
    @(negedge clk);
    clr = 1'b0; vld = '0;
    n_tests++;
    if (o_drop !== 8'd0 || o_ovr !== 4'h0) begin
      n_fail++;
      $display("FAIL clr_priority got drop=%0d ovr=%b exp 0/0000", o_drop, o_ovr);
    end
  endtask

  task automatic test_midreset();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      vld = '0; ack = 1'b0;
      if (c == 0) begin vld = 4'b1010; d[1] = 16'h0101; d[3] = 16'h0303; end
      if (c == 2 || c == 3) begin
        n_tests++;
        if (o_req !== 1'b1) begin
          n_fail++;
          $display("FAIL midrst_pre cycle=%0d got req=%0b exp 1", c, o_req);
        end
      end
      if (c == 3) rst_n = 1'b0;
      if (c == 4) begin
        rst_n = 1'b1;
        ack = 1'b1;
        n_tests++;
        if ({o_req, o_data, o_ch, o_busy, o_ovr, o_tmo, o_drop} !== 32'd0) begin
          n_fail++;
          $display("FAIL midrst_state got req=%0b data=%h ch=%0d busy=%0b exp all 0",
                   o_req, o_data, o_ch, o_busy);
        end
      end
      if (c >= 5) begin
        n_tests++;
        if (o_req !== 1'b0 || o_busy !== 1'b0 || o_tmo !== 1'b0) begin
          n_fail++;
          $display("FAIL midrst_after cycle=%0d got req=%0b busy=%0b tmo=%0b exp 0", c, o_req, o_busy, o_tmo);
        end
      end
      @(negedge clk);
    end
  endtask

  // Randomized traffic against a transaction-level model: per-source latest value,
  // channel free/busy with a free-again cycle after each acknowledge
  task automatic test_random();
    logic [15:0] mval [4];
    bit   [3:0]  mpend = '0;
    bit   [3:0]  movr = '0;
    int          mdrop = 0;
    int          mlast = 3;
    bit          active = 1'b0;
    int          free_at = 0;
    int          eq_ch [$];
    logic [15:0] eq_d [$];
    bit          req_prev = 1'b0;
    int          ack_dly = 0;
    int          req_cnt = 0;
    int          g;
    int          nx = 0;
    do_reset();
    for (int k = 0; k < 4; k++) mval[k] = '0;
    for (int t = 0; t < 3000; t++) begin
      n_tests++;
      if (o_req !== active || o_busy !== (active || t < free_at || mpend != 0)) begin
        n_fail++;
        $display("FAIL rnd_req t=%0d got req=%0b busy=%0b exp req=%0b busy=%0b",
                 t, o_req, o_busy, active, (active || t < free_at || mpend != 0));
      end
      n_tests++;
      if (o_ovr !== movr || o_drop !== 8'(mdrop)) begin
        n_fail++;
        $display("FAIL rnd_flags t=%0d got ovr=%b drop=%0d exp ovr=%b drop=%0d", t, o_ovr, o_drop, movr, mdrop);
      end
      if (o_req && !req_prev) begin
        n_tests++;
        nx++;
        if (eq_ch.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_xfer t=%0d got ch=%0d data=%h exp none", t, o_ch, o_data);
        end else begin
          if (int'(o_ch) != eq_ch[0] || o_data !== eq_d[0]) begin
            n_fail++;
            $display("FAIL rnd_xfer t=%0d got ch=%0d data=%h exp ch=%0d data=%h",
                     t, o_ch, o_data, eq_ch[0], eq_d[0]);
          end
          void'(eq_ch.pop_front());
          void'(eq_d.pop_front());
        end
        req_cnt = 0;
        ack_dly = $urandom_range(0, 3);
      end
      req_prev = o_req;
      // stimulus for cycle t
      vld = 4'($urandom & $urandom);
      for (int k = 0; k < 4; k++) d[k] = 16'($urandom);
      clr = ($urandom_range(0, 63) == 0);
      if (o_req) begin
        ack = (req_cnt == ack_dly);
        req_cnt++;
      end else begin
        ack = ($urandom_range(0, 7) == 0);
      end
      // reference model for cycle t
      g = -1;
      if (active) begin
        if (ack) begin
          active = 1'b0;
          free_at = t + 2;
        end
      end else if (t >= free_at) begin
        for (int i = 1; i <= 4 && g < 0; i++) begin
          if (mpend[(mlast + i) % 4]) g = (mlast + i) % 4;
        end
        if (g >= 0) begin
          eq_ch.push_back(g);
          eq_d.push_back(mval[g]);
          mpend[g] = 1'b0;
          mlast = g;
          active = 1'b1;
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (vld[k]) begin
          if (mpend[k] && g != k) begin
            movr[k] = 1'b1;
            if (mdrop < 255) mdrop++;
          end
          mval[k] = d[k];
          mpend[k] = 1'b1;
        end
      end
      if (clr) begin
        movr = '0;
        mdrop = 0;
      end
      @(negedge clk);
    end
    vld = '0; ack = 1'b0; clr = 1'b0;
    $display("[TB] random: %0d transfers observed", nx);
  endtask

  initial begin
    rst_n = 1'b0;
    vld = '0; ack = 1'b0; clr = 1'b0;
    for (int k = 0; k < 4; k++) d[k] = '0;
    test_reset();
    test_single();
    test_fairness();
    test_overrun();
    test_collision();
    test_timeout();
    test_saturate();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
